// File: rtl/bpm_step_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bpm_step_timer
//  Purpose  : Sequencer step clock. Derives the step period from a live BPM
//             input and a steps-per-beat subdivision using a multi-cycle
//             restoring divider. Produces step/beat/bar pulses and the index
//             of the step just pulsed.
//  Ports    : Clock     - system clock, rising edge
//             Reset     - synchronous, active-high
//             Start     - one-cycle start / resync request
//             Stop      - one-cycle stop request
//             BPM       - tempo in beats per minute, 0 halts
//             Step      - one-cycle pulse per step
//             Beat      - with Step when StepIndex % STEPS_PER_BEAT == 0
//             Bar       - with Step when StepIndex == 0
//             StepIndex - index of the step just pulsed (held between steps)
//             Running   - high while counting steps
//             Busy      - high while the period is being computed
//  Revision : 1.0 - initial release
// ============================================================================
module bpm_step_timer #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BPM_W          = 10,
    parameter int STEPS_PER_BEAT = 4,
    parameter int NUM_STEPS      = 16,
    parameter int STEP_W         = 4,
    parameter int DIV_W          = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic [BPM_W-1:0]  BPM,
    output logic              Step,
    output logic              Beat,
    output logic              Bar,
    output logic [STEP_W-1:0] StepIndex,
    output logic              Running,
    output logic              Busy
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_RUN  = 2'd2;

    // Dividend: clock ticks per minute. Built at 64 bits so the product
    // cannot overflow before being cut down to the datapath width.
    localparam logic [63:0]      c_N_FULL = 64'(CLK_HZ) * 64'd60;
    localparam logic [DIV_W-1:0] c_N      = c_N_FULL[DIV_W-1:0];
    localparam int               c_D_W    = BPM_W + $clog2(STEPS_PER_BEAT);
    localparam int               c_CNT_W  = $clog2(DIV_W + 1);

    logic [1:0]         r_state;
    logic [BPM_W-1:0]   r_bpm;
    logic [DIV_W-1:0]   r_q;
    logic [DIV_W-1:0]   r_tc;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_rem;
    logic [DIV_W-1:0]   r_dvd;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_fresh;

    logic [c_D_W-1:0]   w_d_narrow;
    logic [DIV_W-1:0]   w_div;
    logic [DIV_W:0]     w_rem_sh;
    logic [DIV_W:0]     w_sub;
    logic               w_qbit;
    logic [DIV_W-1:0]   w_p_cl;
    logic [DIV_W-1:0]   w_tc;
    logic [STEP_W-1:0]  w_idx_next;
    logic               w_beat_next;
    logic               w_bpm_zero;

    assign w_bpm_zero = (BPM == '0);

    // Divisor = BPM * steps-per-beat, zero-extended to the datapath width.
    assign w_d_narrow = c_D_W'(BPM) * c_D_W'(STEPS_PER_BEAT);
    assign w_div      = DIV_W'(w_d_narrow);

    // One restoring-division step: the dividend register shifts its MSB into
    // the partial remainder and collects quotient bits at its LSB, so after
    // DIV_W steps it holds the quotient.
    assign w_rem_sh = {r_rem, r_dvd[DIV_W-1]};
    assign w_sub    = w_rem_sh - {1'b0, r_div};
    assign w_qbit   = ~w_sub[DIV_W];

    // Period below 2 cycles cannot produce distinct pulses.
    assign w_p_cl = (r_dvd < DIV_W'(2)) ? DIV_W'(2) : r_dvd;
    assign w_tc   = w_p_cl - DIV_W'(1);

    assign w_idx_next  = (StepIndex == STEP_W'(NUM_STEPS - 1)) ? '0
                                                               : StepIndex + STEP_W'(1);
    assign w_beat_next = ((32'(w_idx_next) % 32'(STEPS_PER_BEAT)) == 32'd0);

    assign Running = (r_state == c_S_RUN);
    assign Busy    = (r_state == c_S_CALC);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= c_S_IDLE;
            r_bpm     <= '0;
            r_q       <= '0;
            r_tc      <= '0;
            r_div     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_cnt     <= '0;
            r_fresh   <= 1'b0;
            Step      <= 1'b0;
            Beat      <= 1'b0;
            Bar       <= 1'b0;
            StepIndex <= '0;
        end else begin
            Step <= 1'b0;
            Beat <= 1'b0;
            Bar  <= 1'b0;
            // A zero tempo while active behaves exactly like Stop.
            if (Stop || ((r_state != c_S_IDLE) && w_bpm_zero)) begin
                r_state   <= c_S_IDLE;
                r_q       <= '0;
                StepIndex <= '0;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (Start && !w_bpm_zero) begin
                            r_bpm     <= BPM;
                            r_div     <= w_div;
                            r_rem     <= '0;
                            r_dvd     <= c_N;
                            r_cnt     <= '0;
                            r_fresh   <= 1'b1;
                            StepIndex <= '0;
                            r_state   <= c_S_CALC;
                        end
                    end
                    c_S_CALC: begin
                        if (r_cnt != c_CNT_W'(DIV_W)) begin
                            r_rem <= w_qbit ? w_sub[DIV_W-1:0] : w_rem_sh[DIV_W-1:0];
                            r_dvd <= {r_dvd[DIV_W-2:0], w_qbit};
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end else begin
                            r_tc    <= w_tc;
                            r_state <= c_S_RUN;
                            // Only a cold start forces an immediate step; a
                            // tempo change resumes the running count.
                            if (r_fresh) begin
                                r_q  <= '0;
                                Step <= 1'b1;
                                Beat <= 1'b1;
                                Bar  <= 1'b1;
                            end
                        end
                    end
                    c_S_RUN: begin
                        if (Start) begin
                            r_q       <= '0;
                            StepIndex <= '0;
                            Step      <= 1'b1;
                            Beat      <= 1'b1;
                            Bar       <= 1'b1;
                        end else if (BPM != r_bpm) begin
                            r_bpm   <= BPM;
                            r_div   <= w_div;
                            r_rem   <= '0;
                            r_dvd   <= c_N;
                            r_cnt   <= '0;
                            r_fresh <= 1'b0;
                            r_state <= c_S_CALC;
                        end else if (r_q >= r_tc) begin
                            // >= rather than == so a count left above a new,
                            // shorter terminal count fires straight away.
                            r_q       <= '0;
                            StepIndex <= w_idx_next;
                            Step      <= 1'b1;
                            Beat      <= w_beat_next;
                            Bar       <= (w_idx_next == '0);
                        end else begin
                            r_q <= r_q + DIV_W'(1);
                        end
                    end
                    default: r_state <= c_S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bpm_step_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bpm_step_timer
//  Purpose  : Self-checking bench for bpm_step_timer. Two instances share the
//             stimulus: one at 1 kHz (normal periods) and one at 10 Hz (the
//             period always clamps to 2 at high tempo).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bpm_step_timer;

    localparam int DIV_W  = 16;
    localparam int SPB    = 4;
    localparam int NSTEPS = 16;
    localparam int M_IDLE = 0;
    localparam int M_CALC = 1;
    localparam int M_RUN  = 2;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Stop  = 1'b0;
    logic [9:0] BPM   = '0;

    logic       Step1, Beat1, Bar1, Running1, Busy1;
    logic [3:0] Idx1;
    logic       Step2, Beat2, Bar2, Running2, Busy2;
    logic [3:0] Idx2;
    logic [8:0] obs0, obs1;

    int checks = 0;
    int fails  = 0;

    // Reference model state (one entry per instance)
    int c_n[2] = '{60000, 600};
    int m_mode[2], m_idx[2], m_q[2], m_tc[2], m_lbpm[2], m_left[2];
    bit m_fresh[2], m_step[2], m_beat[2], m_bar[2];

    always #5 Clock = ~Clock;

    bpm_step_timer #(.CLK_HZ(1000), .BPM_W(10), .STEPS_PER_BEAT(SPB),
                     .NUM_STEPS(NSTEPS), .STEP_W(4), .DIV_W(DIV_W)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .BPM(BPM),
        .Step(Step1), .Beat(Beat1), .Bar(Bar1), .StepIndex(Idx1),
        .Running(Running1), .Busy(Busy1));

    bpm_step_timer #(.CLK_HZ(10), .BPM_W(10), .STEPS_PER_BEAT(SPB),
                     .NUM_STEPS(NSTEPS), .STEP_W(4), .DIV_W(DIV_W)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .BPM(BPM),
        .Step(Step2), .Beat(Beat2), .Bar(Bar2), .StepIndex(Idx2),
        .Running(Running2), .Busy(Busy2));

    assign obs0 = {Step1, Beat1, Bar1, Idx1, Running1, Busy1};
    assign obs1 = {Step2, Beat2, Bar2, Idx2, Running2, Busy2};

    function automatic int period(input int n, input int bpm);
        int p;
        p = n / (bpm * SPB);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic logic [8:0] expv(input int k);
        return {m_step[k], m_beat[k], m_bar[k], 4'(m_idx[k]),
                (m_mode[k] == M_RUN), (m_mode[k] == M_CALC)};
    endfunction

    function automatic void pulse(input int k);
        m_step[k] = 1'b1;
        m_beat[k] = ((m_idx[k] % SPB) == 0);
        m_bar[k]  = (m_idx[k] == 0);
    endfunction

    // Drive one cycle of inputs, advance the model by one edge, settle.
    task automatic tick(input bit rst, input bit st, input bit sp, input logic [9:0] bpm);
        Reset = rst; Start = st; Stop = sp; BPM = bpm;
        @(posedge Clock);
        for (int k = 0; k < 2; k++) begin
            m_step[k] = 1'b0; m_beat[k] = 1'b0; m_bar[k] = 1'b0;
            if (rst) begin
                m_mode[k] = M_IDLE; m_idx[k] = 0; m_q[k] = 0; m_lbpm[k] = 0; m_tc[k] = 0;
            end else if (sp || (m_mode[k] != M_IDLE && bpm == 0)) begin
                m_mode[k] = M_IDLE; m_idx[k] = 0; m_q[k] = 0;
            end else if (m_mode[k] == M_IDLE) begin
                if (st && bpm != 0) begin
                    m_lbpm[k] = int'(bpm); m_idx[k] = 0; m_left[k] = DIV_W + 1;
                    m_fresh[k] = 1'b1; m_mode[k] = M_CALC;
                end
            end else if (m_mode[k] == M_CALC) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_tc[k] = period(c_n[k], m_lbpm[k]) - 1;
                    m_mode[k] = M_RUN;
                    if (m_fresh[k]) begin
                        m_q[k] = 0;
                        pulse(k);
                    end
                end
            end else begin
                if (st) begin
                    m_q[k] = 0; m_idx[k] = 0; pulse(k);
                end else if (int'(bpm) != m_lbpm[k]) begin
                    m_lbpm[k] = int'(bpm); m_left[k] = DIV_W + 1;
                    m_fresh[k] = 1'b0; m_mode[k] = M_CALC;
                end else if (m_q[k] >= m_tc[k]) begin
                    m_q[k] = 0; m_idx[k] = (m_idx[k] + 1) % NSTEPS; pulse(k);
                end else begin
                    m_q[k]++;
                end
            end
        end
        #1;
    endtask

    // Tick with inputs idle until instance 1 steps; n = edges taken, -1 on timeout.
    task automatic wait_step(input int bound, output int n);
        n = 0;
        do begin
            tick(1'b0, 1'b0, 1'b0, BPM);
            n++;
        end while (!Step1 && n < bound);
        if (!Step1) n = -1;
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b0, 1'b0, 10'd60);
        tick(1'b1, 1'b1, 1'b0, 10'd60);
        checks++;
        if (obs0 !== 9'd0 || obs1 !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b/%b required all zero", obs0, obs1);
        end
        tick(1'b0, 1'b0, 1'b0, 10'd60);
        checks++;
        if (obs0 !== expv(0) || obs1 !== expv(1)) begin
            fails++;
            $display("FAIL reset_idle: got %b/%b required %b/%b", obs0, obs1, expv(0), expv(1));
        end
    endtask

    task automatic test_first_step;
        int edges, gap, exp_i, bad;
        bit busy_ok;
        tick(1'b0, 1'b1, 1'b0, 10'd60);
        edges = 0; busy_ok = 1'b1;
        while (edges < 40) begin
            if (!Busy1) busy_ok = 1'b0;
            tick(1'b0, 1'b0, 1'b0, 10'd60);
            edges++;
            if (Step1) break;
        end
        checks++;
        if (edges != DIV_W + 1 || !Step1) begin
            fails++;
            $display("FAIL first_step_latency: got %0d edges required %0d", edges, DIV_W + 1);
        end
        checks++;
        if (!busy_ok || Busy1 !== 1'b0 || Running1 !== 1'b1) begin
            fails++;
            $display("FAIL calc_busy: busy_ok=%0d Busy=%b Running=%b required 1/0/1", busy_ok, Busy1, Running1);
        end
        checks++;
        if ({Beat1, Bar1, Idx1} !== {1'b1, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL first_step_flags: got %b required 110000", {Beat1, Bar1, Idx1});
        end
        gap = 0; exp_i = 0; bad = 0;
        for (int c = 0; c < 16 * 250; c++) begin
            tick(1'b0, 1'b0, 1'b0, 10'd60);
            gap++;
            checks++;
            if (obs0 !== expv(0) || obs1 !== expv(1)) begin
                fails++;
                $display("FAIL bar_model c=%0d: got %b/%b required %b/%b", c, obs0, obs1, expv(0), expv(1));
            end
            if (Step1) begin
                exp_i = (exp_i + 1) % NSTEPS;
                if (gap != 250 || Idx1 !== 4'(exp_i) || Beat1 !== ((exp_i % 4) == 0) ||
                    Bar1 !== (exp_i == 0)) bad++;
                gap = 0;
            end
        end
        checks++;
        if (bad != 0 || exp_i != 0) begin
            fails++;
            $display("FAIL bar_sequence: got %0d bad steps, end index %0d required 0 and 0", bad, exp_i);
        end
    endtask

    task automatic test_bpm_change;
        int n;
        logic [3:0] h;
        wait_step(300, n);
        repeat (100) tick(1'b0, 1'b0, 1'b0, 10'd60);
        h = Idx1;
        tick(1'b0, 1'b0, 1'b0, 10'd120);
        checks++;
        if (Busy1 !== 1'b1 || Running1 !== 1'b0 || Idx1 !== h) begin
            fails++;
            $display("FAIL bpm_change_calc: got busy=%b run=%b idx=%0d required 1/0/%0d", Busy1, Running1, Idx1, h);
        end
        // Held Q=100 resumes against TC=124: 17 calc edges + 25 run edges.
        wait_step(100, n);
        checks++;
        if (n != 42 || Idx1 !== h + 4'd1) begin
            fails++;
            $display("FAIL bpm_change_resume: got %0d edges idx %0d required 42 idx %0d", n, Idx1, h + 4'd1);
        end
        wait_step(200, n);
        checks++;
        if (n != 125) begin
            fails++;
            $display("FAIL bpm120_spacing: got %0d required 125", n);
        end
        repeat (100) tick(1'b0, 1'b0, 1'b0, 10'd120);
        tick(1'b0, 1'b0, 1'b0, 10'd1023);
        // Held Q=100 exceeds new TC=13: fires on the first run cycle.
        wait_step(40, n);
        checks++;
        if (n != 18) begin
            fails++;
            $display("FAIL bpm_change_overrun: got %0d edges required 18", n);
        end
        wait_step(40, n);
        checks++;
        if (n != 14 || obs0 !== expv(0) || obs1 !== expv(1)) begin
            fails++;
            $display("FAIL bpm1023_spacing: got %0d (%b/%b) required 14 (%b/%b)", n, obs0, obs1, expv(0), expv(1));
        end
    endtask

    task automatic test_resync;
        int n;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, 1'b0, 1'b0, 10'd1023);
            if (Step1 && Idx1 == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL resync_wait: got no step at index 7 required one");
        end
        repeat (5) tick(1'b0, 1'b0, 1'b0, 10'd1023);
        tick(1'b0, 1'b1, 1'b0, 10'd1023);
        checks++;
        if ({Step1, Beat1, Bar1, Idx1, Running1} !== {3'b111, 4'd0, 1'b1}) begin
            fails++;
            $display("FAIL resync_pulse: got %b required 11100001", {Step1, Beat1, Bar1, Idx1, Running1});
        end
        wait_step(40, n);
        checks++;
        if (n != 14 || Idx1 !== 4'd1) begin
            fails++;
            $display("FAIL resync_spacing: got %0d idx %0d required 14 idx 1", n, Idx1);
        end
    endtask

    task automatic test_stop_start;
        int n, seen;
        tick(1'b0, 1'b1, 1'b1, 10'd1023);
        checks++;
        if (obs0 !== 9'd0 || obs1 !== 9'd0) begin
            fails++;
            $display("FAIL stop_wins: got %b/%b required all zero", obs0, obs1);
        end
        seen = 0;
        repeat (20) begin
            tick(1'b0, 1'b0, 1'b0, 10'd1023);
            if (Step1 || Busy1 || Running1 || Step2) seen++;
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL stop_idle: got %0d active cycles required 0", seen);
        end
        tick(1'b0, 1'b1, 1'b0, 10'd60);
        wait_step(40, n);
        checks++;
        if (n != DIV_W + 1 || Idx1 !== 4'd0 || Bar1 !== 1'b1) begin
            fails++;
            $display("FAIL restart: got %0d edges idx %0d bar %b required %0d/0/1", n, Idx1, Bar1, DIV_W + 1);
        end
    endtask

    task automatic test_bpm_zero;
        int n, seen;
        tick(1'b0, 1'b0, 1'b1, 10'd60);
        tick(1'b0, 1'b1, 1'b0, 10'd0);
        seen = (obs0 != 9'd0) ? 1 : 0;
        repeat (5) begin
            tick(1'b0, 1'b0, 1'b0, 10'd0);
            if (obs0 != 9'd0 || obs1 != 9'd0) seen++;
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL bpm0_start: got %0d active cycles required 0", seen);
        end
        tick(1'b0, 1'b1, 1'b0, 10'd60);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 10'd60);
        tick(1'b0, 1'b0, 1'b0, 10'd0);
        checks++;
        if (obs0 !== 9'd0 || obs1 !== 9'd0) begin
            fails++;
            $display("FAIL bpm0_in_calc: got %b/%b required all zero", obs0, obs1);
        end
        tick(1'b0, 1'b1, 1'b0, 10'd60);
        wait_step(40, n);
        repeat (10) tick(1'b0, 1'b0, 1'b0, 10'd60);
        tick(1'b0, 1'b0, 1'b0, 10'd0);
        checks++;
        if (obs0 !== 9'd0 || obs1 !== 9'd0 || n != DIV_W + 1) begin
            fails++;
            $display("FAIL bpm0_in_run: got %b/%b (start %0d) required all zero (%0d)", obs0, obs1, n, DIV_W + 1);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        tick(1'b0, 1'b1, 1'b0, 10'd60);
        repeat (5) tick(1'b0, 1'b0, 1'b0, 10'd60);
        tick(1'b1, 1'b0, 1'b0, 10'd60);
        checks++;
        if (obs0 !== 9'd0 || obs1 !== 9'd0) begin
            fails++;
            $display("FAIL reset_mid_calc: got %b/%b required all zero", obs0, obs1);
        end
        tick(1'b0, 1'b1, 1'b0, 10'd60);
        wait_step(40, n);
        repeat (30) tick(1'b0, 1'b0, 1'b0, 10'd60);
        tick(1'b1, 1'b0, 1'b0, 10'd60);
        checks++;
        if (obs0 !== 9'd0 || obs1 !== 9'd0) begin
            fails++;
            $display("FAIL reset_mid_run: got %b/%b required all zero", obs0, obs1);
        end
        tick(1'b0, 1'b0, 1'b0, 10'd60);
        checks++;
        if (obs0 !== 9'd0 || obs1 !== expv(1)) begin
            fails++;
            $display("FAIL reset_stays_idle: got %b/%b required all zero", obs0, obs1);
        end
    endtask

    task automatic test_clamp;
        int n, bad;
        tick(1'b0, 1'b1, 1'b0, 10'd1023);
        wait_step(40, n);
        checks++;
        if (n != DIV_W + 1 || Step2 !== 1'b1 || Idx2 !== 4'd0) begin
            fails++;
            $display("FAIL clamp_first: got %0d edges step2=%b required %0d/1", n, Step2, DIV_W + 1);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b0, 10'd1023);
            if (Step2 !== (i % 2 == 1)) bad++;
            if (Step2 && Idx2 !== 4'((i / 2 + 1) % NSTEPS)) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL clamp_period2: got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_random;
        bit rst, st, sp;
        logic [9:0] b;
        b = 10'd60;
        tick(1'b0, 1'b1, 1'b0, b);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 999) == 0);
            st  = ($urandom_range(0, 79) == 0);
            sp  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 5))
                    0: b = 10'd0;
                    1: b = 10'd60;
                    2: b = 10'd120;
                    3: b = 10'd1023;
                    4: b = 10'($urandom_range(1, 1023));
                    default: b = 10'($urandom_range(1, 40));
                endcase
            end
            tick(rst, st, sp, b);
            checks++;
            if (obs0 !== expv(0) || obs1 !== expv(1)) begin
                fails++;
                $display("FAIL random c=%0d: got %b/%b required %b/%b", c, obs0, obs1, expv(0), expv(1));
            end
        end
    endtask

    initial begin
        test_reset;
        test_first_step;
        test_bpm_change;
        test_resync;
        test_stop_start;
        test_bpm_zero;
        test_reset_mid;
        test_clamp;
        test_random;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
